cdiv: RTL and testbench

- Sequential complex divider: computes Q = A / B on packed complex integer operands.
- Same WIDTH-packed format as the datapath's complex multiplier: upper half real, lower half imaginary, each half signed two's complement.
- Computes Q = A·conj(B) / |B|² using one shared H×H signed multiplier, then two parallel restoring dividers.
- Sits alongside the complex multiplier in the complex-arithmetic datapath and uses the same start/ready style.

---
 rtl/cdiv.sv | 169 ++++++++++++++++
 tb/tb_cdiv.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cdiv.sv
// Sequential complex divider Q = A*conj(B)/|B|^2 on packed {re, im} signed halves.
// Optional CDIV_SAT_EN: clamp each result component instead of wrapping to H bits.
module cdiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quot
);
  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * H;
  localparam int WN = W2 + 1;
  localparam int CW = $clog2(WN + 1);
`ifdef CDIV_SAT_EN
  localparam logic [WN-1:0] MAGP = WN'((1 << (H - 1)) - 1);
  localparam logic [WN-1:0] MAGN = WN'(1 << (H - 1));
`endif

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_SUM, S_DIV, S_FIX, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]        a_q, b_q;
  logic [5:0][W2-1:0]      prod_q;
  logic [1:0][WN-1:0]      num_q, rem_q, num_d, rem_d;
  logic [1:0][WN:0]        trial;
  logic [WN-1:0]           den_q;
  logic [1:0]              neg_q;
  logic                    zero_q, dbz_q;
  logic [WIDTH-1:0]        quot_q;

  logic [H-1:0]            op_a, op_b, op_c, op_d, mx, my;
  logic [W2-1:0]           mp;
  logic [WN-1:0]           nr, ni, den, nr_mag, ni_mag;
  logic [1:0][H-1:0]       res;

  assign op_a = a_q[WIDTH-1:H];
  assign op_b = a_q[H-1:0];
  assign op_c = b_q[WIDTH-1:H];
  assign op_d = b_q[H-1:0];

  // One shared multiplier; product order is ac, bd, bc, ad, cc, dd.
  always_comb begin
    mx = op_d;
    my = op_d;
    case (cnt_q)
      CW'(0): begin mx = op_a; my = op_c; end
      CW'(1): begin mx = op_b; my = op_d; end
      CW'(2): begin mx = op_b; my = op_c; end
      CW'(3): begin mx = op_a; my = op_d; end
      CW'(4): begin mx = op_c; my = op_c; end
      default: ;
    endcase
  end
  // Sign-extended operands: the low W2 bits of the product are the exact signed result.
  assign mp = {{H{mx[H-1]}}, mx} * {{H{my[H-1]}}, my};

  assign nr     = {prod_q[0][W2-1], prod_q[0]} + {prod_q[1][W2-1], prod_q[1]};
  assign ni     = {prod_q[2][W2-1], prod_q[2]} - {prod_q[3][W2-1], prod_q[3]};
  assign den    = {1'b0, prod_q[4]} + {1'b0, prod_q[5]};
  assign nr_mag = nr[WN-1] ? (~nr + 1'b1) : nr;
  assign ni_mag = ni[WN-1] ? (~ni + 1'b1) : ni;

  // Restoring step: quotient bits shift into num from the LSB as dividend bits leave the MSB.
  always_comb begin
    trial = '0;
    num_d = num_q;
    rem_d = rem_q;
    for (int i = 0; i < 2; i++) begin
      trial[i] = {rem_q[i], num_q[i][WN-1]};
      if (trial[i] >= {1'b0, den_q}) begin
        rem_d[i] = trial[i][WN-1:0] - den_q;
        num_d[i] = {num_q[i][WN-2:0], 1'b1};
      end else begin
        rem_d[i] = trial[i][WN-1:0];
        num_d[i] = {num_q[i][WN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < 2; i++) begin
`ifdef CDIV_SAT_EN
      if (!neg_q[i])
        res[i] = (num_q[i] > MAGP) ? {1'b0, {(H-1){1'b1}}} : num_q[i][H-1:0];
      else
        res[i] = (num_q[i] > MAGN) ? {1'b1, {(H-1){1'b0}}} : (~num_q[i][H-1:0] + 1'b1);
`else
      res[i] = neg_q[i] ? (~num_q[i][H-1:0] + 1'b1) : num_q[i][H-1:0];
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start) begin state_d = S_MUL; cnt_d = '0; end
      S_MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(5)) state_d = S_SUM;
      end
      S_SUM: begin state_d = S_DIV; cnt_d = '0; end
      S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WN - 1)) state_d = S_FIX;
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      neg_q   <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && start) begin
        a_q   <= A;
        b_q   <= B;
        dbz_q <= 1'b0;
      end
      if (state_q == S_MUL)
        for (int k = 0; k < 6; k++)
          if (cnt_q == CW'(k)) prod_q[k] <= mp;
      if (state_q == S_SUM) begin
        num_q  <= {ni_mag, nr_mag};
        rem_q  <= '0;
        den_q  <= den;
        neg_q  <= {ni[WN-1], nr[WN-1]};
        zero_q <= (den == '0);
      end
      // A zero divisor still walks the DIV cycles; FIX then forces the result.
      if (state_q == S_DIV) begin
        num_q <= num_d;
        rem_q <= rem_d;
      end
      if (state_q == S_FIX) begin
        quot_q <= zero_q ? '0 : {res[0], res[1]};
        dbz_q  <= zero_q;
      end
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign ready       = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign quot        = quot_q;
endmodule

// File: tb/tb_cdiv.sv
// Directed bench for cdiv (WIDTH=8): vector table plus multi-cycle control sequences.
module tb_cdiv;
  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] A, B;
  logic       busy, ready, div_by_zero;
  logic [7:0] quot;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] SATV =
`ifdef CDIV_SAT_EN
    8'h70;
`else
    8'h80;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic       dz;
  } vec_t;

  vec_t tv[12];

  cdiv #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .ready(ready), .div_by_zero(div_by_zero), .quot(quot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the negedge after the accepting edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Edges counted from the accepting edge; k0 edges have already elapsed.
  task automatic wait_ready(input int k0, output int lat);
    lat = 0;
    for (int k = k0 + 1; k <= 40; k++) begin
      cyc();
      if (ready) begin lat = k; break; end
    end
  endtask

  task automatic count_ready(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      cyc();
      if (ready) cnt++;
    end
  endtask

  initial begin
    int lat, cnt;
    tv[0]  = '{8'h55, 8'h12, 8'h3F, 1'b0};
    tv[1]  = '{8'h70, 8'h20, 8'h30, 1'b0};
    tv[2]  = '{8'h90, 8'h20, 8'hD0, 1'b0};
    tv[3]  = '{8'h37, 8'h00, 8'h00, 1'b1};
    tv[4]  = '{8'h23, 8'h10, 8'h23, 1'b0};
    tv[5]  = '{8'h80, 8'hF0, SATV,  1'b0};
    tv[6]  = '{8'h7F, 8'h11, 8'h3C, 1'b0};
    tv[7]  = '{8'h1F, 8'h01, 8'hFF, 1'b0};
    tv[8]  = '{8'h88, 8'hFF, SATV,  1'b0};
    tv[9]  = '{8'h11, 8'h77, 8'h00, 1'b0};
    tv[10] = '{8'h00, 8'h11, 8'h00, 1'b0};
    tv[11] = '{8'h71, 8'h13, 8'h1E, 1'b0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_quot", quot, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      launch(tv[i].a, tv[i].b);
      chk($sformatf("busy_%0d", i), busy, 1);
      wait_ready(0, lat);
      chk($sformatf("lat_%0d", i), lat, 17);
      chk($sformatf("quot_%0d", i), quot, tv[i].q);
      chk($sformatf("dbz_%0d", i), div_by_zero, tv[i].dz);
      chk($sformatf("done_busy_%0d", i), busy, 0);
    end

    // Zero-divisor flag and zero quotient hold after the pulse.
    launch(8'h37, 8'h00);
    wait_ready(0, lat);
    chk("dz_lat", lat, 17);
    cyc(); cyc(); cyc();
    chk("dz_hold_flag", div_by_zero, 1);
    chk("dz_hold_quot", quot, 0);
    chk("dz_hold_ready", ready, 0);

    // Operands captured at start; later changes ignored.
    launch(8'h55, 8'h12);
    cyc(); cyc(); cyc();
    A = 8'h11; B = 8'h77;
    wait_ready(3, lat);
    chk("cap_lat", lat, 17);
    chk("cap_quot", quot, 8'h3F);
    chk("cap_dbz", div_by_zero, 0);

    // Start pulse while busy is neither restarted nor queued.
    launch(8'h70, 8'h20);
    cyc(); cyc(); cyc(); cyc();
    A = 8'h11; B = 8'h00; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_ready(5, lat);
    chk("busy_start_lat", lat, 17);
    chk("busy_start_quot", quot, 8'h30);
    chk("busy_start_dbz", div_by_zero, 0);
    // Start raised during DONE is ignored as well.
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("done_start_busy", busy, 0);
    count_ready(25, cnt);
    chk("no_extra_ready", cnt, 0);
    chk("no_extra_busy", busy, 0);

    // Reset in MUL cycle 5 aborts without a ready.
    launch(8'h55, 8'h12);
    cyc(); cyc(); cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    chk("abort_busy", busy, 0);
    chk("abort_ready", ready, 0);
    chk("abort_quot", quot, 0);
    chk("abort_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    count_ready(30, cnt);
    chk("abort_no_ready", cnt, 0);

    // Recovers cleanly after the abort.
    launch(8'h71, 8'h13);
    wait_ready(0, lat);
    chk("post_lat", lat, 17);
    chk("post_quot", quot, 8'h1E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
